// File: rtl/table_wr_packer.sv
// table_wr_packer: buffers single-entry table writes in a FIFO and packs up to INPUT_RATE per cycle onto the wide write bus
module table_wr_packer #(
  parameter int TABLE_SIZE = 32,
  parameter int DATA_WIDTH = 8,
  parameter int INPUT_RATE = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int FLUSH_TIMEOUT = 4,
  localparam int IW = $clog2(TABLE_SIZE),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [IW-1:0]                    req_index,
  input  logic [DATA_WIDTH-1:0]            req_data,
  input  logic                             flush,
  output logic                             wr_en,
  output logic [INPUT_RATE*IW-1:0]         index_wr,
  output logic [INPUT_RATE*DATA_WIDTH-1:0] data_wr,
  output logic [CW-1:0]                    pending
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = FLUSH_TIMEOUT > 1 ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam int EW = IW + DATA_WIDTH;
  localparam int AW = CW + 1;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, n;
  logic [TW-1:0] tmr;
  logic push, full, part;
  logic [INPUT_RATE*IW-1:0] idx_n;
  logic [INPUT_RATE*DATA_WIDTH-1:0] dat_n;

  // Pointer sums never reach twice the depth, so one conditional subtract wraps them.
  function automatic logic [PW-1:0] wrap(input logic [AW-1:0] p);
    return p >= AW'(FIFO_DEPTH) ? PW'(p - AW'(FIFO_DEPTH)) : PW'(p);
  endfunction

  assign req_ready = !rst && count < CW'(FIFO_DEPTH);
  assign push = req_valid && req_ready;
  assign full = count >= CW'(INPUT_RATE);
  assign part = count != '0 && !full && (flush || tmr == TW'(FLUSH_TIMEOUT - 1));
  assign n = full ? CW'(INPUT_RATE) : part ? count : '0;
  assign pending = count;

  // Lane k reads entry head+k; lanes past the batch size repeat the newest popped entry.
  for (genvar k = 0; k < INPUT_RATE; k++) begin : g_lane
    logic [CW-1:0] off;
    logic [EW-1:0] ent;
    assign off = (CW'(k) < n || n == '0) ? CW'(k) : n - CW'(1);
    assign ent = mem[wrap(AW'(head) + AW'(off))];
    assign idx_n[k*IW +: IW] = ent[EW-1 -: IW];
    assign dat_n[k*DATA_WIDTH +: DATA_WIDTH] = ent[DATA_WIDTH-1:0];
  end

  // Request storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk)
    if (push) mem[tail] <= {req_index, req_data};

  // Pointers, occupancy, batch timer and the registered write bus.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      tmr <= '0;
      wr_en <= 1'b0;
      index_wr <= '0;
      data_wr <= '0;
    end else begin
      if (push) tail <= wrap(AW'(tail) + AW'(1));
      head <= wrap(AW'(head) + AW'(n));
      count <= count + CW'(push) - n;
      tmr <= (count == '0 || n != '0) ? '0 : tmr == TW'(FLUSH_TIMEOUT - 1) ? tmr : tmr + TW'(1);
      wr_en <= n != '0;
      if (n != '0) begin
        index_wr <= idx_n;
        data_wr <= dat_n;
      end
    end
endmodule

// File: tb/tb_table_wr_packer.sv
// tb_table_wr_packer: directed checks of batching, timeout, flush, ordering and reset
module tb_table_wr_packer;
  localparam int IW = 5;
  localparam int DW = 8;
  localparam int R = 2;

  logic clk = 0, rst = 0, req_valid = 0, flush = 0;
  logic [IW-1:0] req_index = '0;
  logic [DW-1:0] req_data = '0;
  logic req_ready, wr_en;
  logic [R*IW-1:0] index_wr;
  logic [R*DW-1:0] data_wr;
  logic [3:0] pending;
  int errors = 0, checks = 0, nbat = 0, nb0, q0;
  logic [IW+DW-1:0] log_q[$];
  logic [DW-1:0] tbl [32];

  always #5 clk = ~clk;

  table_wr_packer #(.TABLE_SIZE(32), .DATA_WIDTH(DW), .INPUT_RATE(R), .FIFO_DEPTH(8), .FLUSH_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_data(req_data), .flush(flush), .wr_en(wr_en), .index_wr(index_wr), .data_wr(data_wr),
    .pending(pending)
  );

  // Table model: lanes applied low to high, so the newest lane wins on duplicates.
  always @(posedge clk)
    if (wr_en) begin
      nbat <= nbat + 1;
      for (int k = 0; k < R; k++) begin
        log_q.push_back({index_wr[k*IW +: IW], data_wr[k*DW +: DW]});
        tbl[index_wr[k*IW +: IW]] <= data_wr[k*DW +: DW];
      end
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1;
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_index", 32'(index_wr), 0);
    chk("rst_data", 32'(data_wr), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ready", 32'(req_ready), 0);
    step;
    step;
    rst = 0;
    step;
    chk("idle_ready", 32'(req_ready), 1);

    req_valid = 1; req_index = 3; req_data = 8'hAA;
    step;
    req_index = 7; req_data = 8'hBB;
    step;
    req_valid = 0;
    chk("full_pending2", 32'(pending), 2);
    chk("full_wr_en_pre", 32'(wr_en), 0);
    step;
    chk("full_wr_en", 32'(wr_en), 1);
    chk("full_index", 32'(index_wr), 32'({5'd7, 5'd3}));
    chk("full_data", 32'(data_wr), 32'h BBAA);
    chk("full_pending0", 32'(pending), 0);
    step;
    chk("full_strobe_end", 32'(wr_en), 0);

    req_valid = 1; req_index = 5; req_data = 8'h11;
    step;
    req_valid = 0;
    chk("to_wr_en_e0", 32'(wr_en), 0);
    chk("to_pending", 32'(pending), 1);
    for (int i = 1; i <= 3; i++) begin
      step;
      chk("to_wr_en_early", 32'(wr_en), 0);
    end
    step;
    chk("to_wr_en", 32'(wr_en), 1);
    chk("to_index", 32'(index_wr), 32'({5'd5, 5'd5}));
    chk("to_data", 32'(data_wr), 32'h1111);
    chk("to_pending0", 32'(pending), 0);

    req_valid = 1; req_index = 9; req_data = 8'h22;
    step;
    req_valid = 0; flush = 1;
    chk("fl_wr_en_pre", 32'(wr_en), 0);
    step;
    chk("fl_wr_en", 32'(wr_en), 1);
    chk("fl_index", 32'(index_wr), 32'({5'd9, 5'd9}));
    chk("fl_data", 32'(data_wr), 32'h2222);
    flush = 0;
    chk("fl_pending0", 32'(pending), 0);

    req_valid = 1; req_index = 4; req_data = 8'h01;
    step;
    req_data = 8'h02;
    step;
    req_valid = 0;
    step;
    chk("dup_wr_en", 32'(wr_en), 1);
    chk("dup_index", 32'(index_wr), 32'({5'd4, 5'd4}));
    chk("dup_data", 32'(data_wr), 32'h0201);
    step;
    chk("dup_tbl4", 32'(tbl[4]), 32'h02);
    chk("tbl3", 32'(tbl[3]), 32'hAA);
    chk("tbl7", 32'(tbl[7]), 32'hBB);

    nb0 = nbat;
    q0 = log_q.size();
    for (int i = 0; i < 16; i++) begin
      req_valid = 1; req_index = 5'(i * 3 + 1); req_data = 8'(8'h40 + i);
      chk("b2b_ready", 32'(req_ready), 1);
      step;
    end
    req_valid = 0;
    repeat (3) step;
    chk("b2b_batches", 32'(nbat - nb0), 8);
    chk("b2b_pending0", 32'(pending), 0);
    for (int i = 0; i < 16; i++)
      chk("b2b_order", (q0 + i < log_q.size()) ? 32'(log_q[q0+i]) : 32'hFFFF_FFFF,
          32'({5'(i * 3 + 1), 8'(8'h40 + i)}));

    req_valid = 1; req_index = 2; req_data = 8'h77;
    step;
    req_valid = 0;
    step;
    chk("rm_pending1", 32'(pending), 1);
    rst = 1;
    #1;
    chk("rm_wr_en", 32'(wr_en), 0);
    chk("rm_index", 32'(index_wr), 0);
    chk("rm_data", 32'(data_wr), 0);
    chk("rm_pending", 32'(pending), 0);
    chk("rm_ready", 32'(req_ready), 0);
    step;
    rst = 0;
    nb0 = nbat;
    repeat (10) step;
    chk("rm_no_issue", 32'(nbat - nb0), 0);
    chk("rm_pending_after", 32'(pending), 0);
    chk("rm_ready_after", 32'(req_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
